// File: rtl/fir_result_bcd_decoder_if.sv
// Handshake bundle between the FIR result producer, the BCD decoder and the display consumer.
// The decoder takes the slave view; the producer/consumer side takes the master view.
interface fir_result_bcd_decoder_if #(
  parameter int W      = 12,
  parameter int DIGITS = 4
);
  logic [W-1:0]          i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_busy;

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_ready,
    output o_ready,
    output o_bcd,
    output o_valid,
    output o_busy
  );

  modport master (
    output i_data,
    output i_valid,
    output i_ready,
    input  o_ready,
    input  o_bcd,
    input  o_valid,
    input  o_busy
  );
endinterface

// File: rtl/fir_result_bcd_decoder.sv
// Sequential double-dabble converter of a FIR result (hundredths) into packed BCD D3 D2 . D1 D0.
// Optional macro FIR_BCD_ROUND_EN: adds 5 before conversion and clears D0 (round half-up to tenths).
module fir_result_bcd_decoder #(
  parameter int W      = 12,
  parameter int DIGITS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  fir_result_bcd_decoder_if.slave bus
);

`ifdef FIR_BCD_ROUND_EN
  localparam int OPW   = W + 1;
  localparam int STEPS = W + 1;
`else
  // Exact mode never needs the zero-extension bit, so the operand is just W bits wide.
  localparam int OPW   = W;
  localparam int STEPS = W;
`endif
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [OPW-1:0]    op_q;
  logic [OPW-1:0]    op_d;
  logic [OPW-1:0]    op_load_s;
  logic [SW-1:0]     scr_q;
  logic [SW-1:0]     scr_adj_s;
  logic [SW-1:0]     scr_d;
  logic [SW-1:0]     bcd_q;
  logic [SW-1:0]     bcd_d;
  logic [CW-1:0]     cnt_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;

  function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
    if (digit >= 4'd5) begin
      return digit + 4'd3;
    end else begin
      return digit;
    end
  endfunction

  // One double-dabble step: adjust all digits, then shift the operand MSB into the scratch.
  always_comb begin
    scr_adj_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      scr_adj_s[4*i +: 4] = dd_adjust(scr_q[4*i +: 4]);
    end
    scr_d = {scr_adj_s[SW-2:0], op_q[OPW-1]};
    op_d  = {op_q[OPW-2:0], 1'b0};
    bcd_d = scr_d;
`ifdef FIR_BCD_ROUND_EN
    bcd_d[3:0] = 4'd0;
    op_load_s  = {1'b0, bus.i_data} + OPW'(5);
`else
    op_load_s  = bus.i_data;
`endif
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (ready_q && bus.i_valid) begin
            op_q    <= op_load_s;
            scr_q   <= '0;
            cnt_q   <= CW'(STEPS);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          scr_q <= scr_d;
          op_q  <= op_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= bcd_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bcd   = bcd_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ready = ready_q;
  assign bus.o_busy  = busy_q;

endmodule
